xmpl_dsp_cic: RTL and testbench

//  First stage of the xmpl_dsp chain: an N-stage CIC decimator (differential delay 1).

---
 rtl/xmpl_dsp_pkg.sv | 18 +
 rtl/xmpl_dsp_cic_comb_stage.sv | 25 ++
 rtl/xmpl_dsp_cic.sv | 111 +++++++++++
 tb/tb_xmpl_dsp_cic.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/xmpl_dsp_pkg.sv
// xmpl_dsp_pkg: shared state encoding, width constants and width helper for the xmpl_dsp chain
package xmpl_dsp_pkg;
    typedef enum logic [1:0] {
        CIC_IDLE  = 2'd0,
        CIC_FLUSH = 2'd1,
        CIC_RUN   = 2'd2,
        CIC_DONE  = 2'd3
    } cic_state_e;

    localparam int CIC_DATA_W    = 16;
    localparam int CIC_STAGES    = 3;
    localparam int CIC_DEC_R     = 8;
    localparam int CIC_FRAME_LEN = 64;

    function automatic int cic_out_w(input int data_w, input int stages, input int dec_r);
        return data_w + stages * $clog2(dec_r);
    endfunction
endpackage

// File: rtl/xmpl_dsp_cic_comb_stage.sv
// xmpl_dsp_cic_comb_stage: one registered CIC comb y = x - x_d, advancing only on enable
module xmpl_dsp_cic_comb_stage #(
    parameter int W = 25
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                clr,
    input  logic signed [W-1:0] x,
    output logic signed [W-1:0] y
);
    logic signed [W-1:0] x_d;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            y   <= '0;
            x_d <= '0;
        end else if (clr) begin
            y   <= '0;
            x_d <= '0;
        end else if (en) begin
            y   <= x - x_d;
            x_d <= x;
        end
endmodule

// File: rtl/xmpl_dsp_cic.sv
// xmpl_dsp_cic: N-stage CIC decimator producing FRAME_LEN-sample frames, gated by the chain FSM
module xmpl_dsp_cic
    import xmpl_dsp_pkg::*;
#(
    parameter  int DATA_W    = CIC_DATA_W,
    parameter  int STAGES    = CIC_STAGES,
    parameter  int DEC_R     = CIC_DEC_R,
    parameter  int FRAME_LEN = CIC_FRAME_LEN,
    localparam int OUT_W     = cic_out_w(DATA_W, STAGES, DEC_R)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     en_xmpl_dsp_cic_i,
    input  logic                     din_valid_i,
    input  logic signed [DATA_W-1:0] din_i,
    output logic                     dout_valid_o,
    output logic signed [OUT_W-1:0]  dout_o,
    output logic                     xmpl_dsp_cic_status_o,
    output logic [1:0]               cic_state_o
);
    localparam int CNT_W = $clog2(DEC_R);
    localparam int FRM_W = $clog2(FRAME_LEN + 1);

    cic_state_e state, state_nxt;
    logic run, flush, acc, mark;
    logic [CNT_W-1:0] dec_cnt;
    logic [FRM_W-1:0] frm_cnt;
    logic [STAGES-1:0] vp;
    logic [2*STAGES-1:0] sp;
    logic dout_v_q;
    logic signed [OUT_W-1:0] dout_q;
    logic signed [OUT_W-1:0] integ [STAGES];
    logic signed [OUT_W-1:0] cin [STAGES];
    logic signed [OUT_W-1:0] comb [STAGES];

    assign run   = state == CIC_RUN;
    assign flush = state == CIC_FLUSH;
    assign acc   = run && din_valid_i;
    assign mark  = acc && dec_cnt == CNT_W'(DEC_R - 1);

    // Dropping enable must silence the outputs in the same cycle, not one later.
    assign dout_valid_o          = dout_v_q && run && en_xmpl_dsp_cic_i;
    assign xmpl_dsp_cic_status_o = state == CIC_DONE && en_xmpl_dsp_cic_i;
    assign dout_o                = dout_q;
    assign cic_state_o           = state;

    always_comb begin
        state_nxt = !en_xmpl_dsp_cic_i ? CIC_IDLE :
                    state == CIC_IDLE  ? CIC_FLUSH :
                    state == CIC_FLUSH ? CIC_RUN :
                    (dout_valid_o && frm_cnt == FRM_W'(FRAME_LEN - 1)) ? CIC_DONE : state;
    end

    // vp tracks each sample through the integrator pipe; sp carries the decimation mark through integrators and combs.
    always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i) begin
            state    <= CIC_IDLE;
            dec_cnt  <= '0;
            frm_cnt  <= '0;
            vp       <= '0;
            sp       <= '0;
            dout_v_q <= 1'b0;
            dout_q   <= '0;
        end else begin
            state <= state_nxt;
            if (flush) begin
                dec_cnt  <= '0;
                frm_cnt  <= '0;
                vp       <= '0;
                sp       <= '0;
                dout_v_q <= 1'b0;
            end else begin
                dec_cnt  <= acc ? dec_cnt + CNT_W'(1) : dec_cnt;
                frm_cnt  <= dout_valid_o ? frm_cnt + FRM_W'(1) : frm_cnt;
                vp       <= run ? STAGES'({vp, acc}) : '0;
                sp       <= run ? (2*STAGES)'({sp, mark}) : '0;
                dout_v_q <= run && sp[2*STAGES-1];
                if (run && sp[2*STAGES-1])
                    dout_q <= comb[STAGES-1];
            end
        end

    always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i) begin
            for (int k = 0; k < STAGES; k++) integ[k] <= '0;
        end else if (flush) begin
            for (int k = 0; k < STAGES; k++) integ[k] <= '0;
        end else begin
            if (acc)
                integ[0] <= integ[0] + OUT_W'(din_i);
            for (int k = 1; k < STAGES; k++)
                if (run && vp[k-1])
                    integ[k] <= integ[k] + integ[k-1];
        end

    assign cin[0] = integ[STAGES-1];
    for (genvar g = 1; g < STAGES; g++) begin : g_cin
        assign cin[g] = comb[g-1];
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_comb
        xmpl_dsp_cic_comb_stage #(.W(OUT_W)) u_comb (
            .clk   (clk_i),
            .rst_n (reset_n_i),
            .en    (run && sp[STAGES-1+g]),
            .clr   (flush),
            .x     (cin[g]),
            .y     (comb[g])
        );
    end
endmodule

// File: tb/tb_xmpl_dsp_cic.sv
// tb_xmpl_dsp_cic: directed checks of the CIC decimator with FRAME_LEN=4
module tb_xmpl_dsp_cic;
    logic clk = 1'b0;
    logic reset_n;
    logic en;
    logic din_valid;
    logic signed [15:0] din;
    logic dout_valid;
    logic signed [24:0] dout;
    logic status;
    logic [1:0] state;

    int n_cmp = 0;
    int n_bad = 0;
    logic signed [24:0] vals[$];
    int cycs[$];
    int stat_cyc;

    always #5 clk = ~clk;

    xmpl_dsp_cic #(.DATA_W(16), .STAGES(3), .DEC_R(8), .FRAME_LEN(4)) dut (
        .clk_i                 (clk),
        .reset_n_i             (reset_n),
        .en_xmpl_dsp_cic_i     (en),
        .din_valid_i           (din_valid),
        .din_i                 (din),
        .dout_valid_o          (dout_valid),
        .dout_o                (dout),
        .xmpl_dsp_cic_status_o (status),
        .cic_state_o           (state)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Runs n cycles, logging every output strobe and the first status cycle; gap>0 pulses din_valid 1-of-gap.
    task automatic run(input int n, input int gap);
        vals.delete();
        cycs.delete();
        stat_cyc = -1;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            if (dout_valid === 1'b1) begin
                vals.push_back(dout);
                cycs.push_back(i);
            end
            if (status === 1'b1 && stat_cyc < 0) stat_cyc = i;
            if (gap > 0) din_valid = (i % gap) == 0;
        end
    endtask

    // 3-stage, R=8 step response at the strobes: C(n+2,3) through three combs -> 120, 456, 512, 512.
    task automatic expect_frame(input string tag, input int unit, input bit timed);
        int coef[4] = '{120, 456, 512, 512};
        chk({tag, "_count"}, vals.size(), 4);
        for (int k = 0; k < 4 && k < vals.size(); k++) begin
            chk($sformatf("%s_val%0d", tag, k), vals[k], unit * coef[k]);
            if (timed)
                chk($sformatf("%s_cyc%0d", tag, k), cycs[k], 16 + 8 * k);
            else if (k > 0)
                chk($sformatf("%s_gap%0d", tag, k), cycs[k] - cycs[k-1], 24);
        end
        if (vals.size() == 4)
            chk({tag, "_status_cyc"}, stat_cyc, timed ? 41 : cycs[3] + 1);
    endtask

    initial begin
        reset_n = 1'b0;
        en = 1'b0;
        din_valid = 1'b0;
        din = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout", dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_status", status, 0);
        chk("rst_state", state, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        din = 16'sd1;
        din_valid = 1'b1;
        en = 1'b1;
        run(45, 0);
        expect_frame("dc", 1, 1'b1);
        chk("dc_state_done", state, 3);
        chk("dc_status_held", status, 1);

        din = 16'sd1000;
        run(8, 0);
        chk("done_no_out", vals.size(), 0);
        chk("done_status", status, 1);

        en = 1'b0;
        run(4, 0);
        chk("idle_no_out", vals.size(), 0);
        chk("idle_state", state, 0);
        chk("idle_status", status, 0);

        din = -16'sd32768;
        en = 1'b1;
        run(45, 0);
        expect_frame("negfs", -32768, 1'b1);

        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_rst_dout", dout, 0);
        chk("async_rst_valid", dout_valid, 0);
        chk("async_rst_status", status, 0);
        chk("async_rst_state", state, 0);
        en = 1'b0;
        din_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        din = 16'sd1;
        en = 1'b1;
        run(130, 3);
        expect_frame("gap", 1, 1'b0);

        en = 1'b0;
        din_valid = 1'b0;
        run(2, 0);

        din_valid = 1'b1;
        en = 1'b1;
        run(31, 0);
        chk("abort_pre_count", vals.size(), 2);
        if (vals.size() == 2) begin
            chk("abort_pre_val0", vals[0], 120);
            chk("abort_pre_val1", vals[1], 456);
        end
        @(posedge clk);
        #1;
        chk("abort_third_pulse", dout_valid, 1);
        en = 1'b0;
        #1;
        chk("abort_valid_forced", dout_valid, 0);
        chk("abort_status", status, 0);
        @(posedge clk);
        #1;
        chk("abort_state_idle", state, 0);
        chk("abort_valid_idle", dout_valid, 0);
        en = 1'b1;
        run(45, 0);
        expect_frame("restart", 1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
